// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small valid/ready FIFO. Bit timing comes from a
// baud prescaler and an oversample tick counter so it matches the receive path.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_AW    = 2
) (
    input  logic             clk_50mhz,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic             tx_done,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int TICKS_PER_BIT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DEPTH         = 2 ** FIFO_AW;
    localparam int BAUD_W        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int TICK_W        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [FIFO_AW:0]  DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];

    logic push;
    logic pop;
    logic baud_tick;
    logic bit_end;

    always_comb begin
        tx_ready   = (count_q != DEPTH_CNT);
        push       = tx_valid && tx_ready;
        baud_tick  = (baud_cnt_q == BAUD_LAST);
        bit_end    = baud_tick && (tick_cnt_q == TICK_LAST);
        busy       = (state_q != IDLE);
        tx         = tx_q;
        fifo_count = count_q;
        tx_done    = (state_q == STOP) && bit_end;
    end

    // Counters idle at zero so every frame starts phase-aligned to its load edge.
    always_comb begin
        baud_cnt_d = '0;
        tick_cnt_d = '0;
        if (state_q != IDLE) begin
            baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 1'b1;
            tick_cnt_d = tick_cnt_q;
            if (baud_tick) begin
                tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Datapath storage carries no reset; stale contents are never read after reset.
    always_ff @(posedge clk_50mhz) begin
        shift_q <= shift_d;
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule
